// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: control and serial/parallel data in,
// registered word, serial tap and frame status out.
interface universal_shift_register_if #(
   parameter int WIDTH = 4
);
   localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

   logic [1:0]       mode;
   logic             si;
   logic [WIDTH-1:0] pi;
   logic [WIDTH-1:0] po;
   logic             so;
   logic [CW-1:0]    bit_count;
   logic             frame_done;

   modport master (
      output mode, si, pi,
      input  po, so, bit_count, frame_done
   );

   modport slave (
      input  mode, si, pi,
      output po, so, bit_count, frame_done
   );
endinterface

// File: rtl/universal_shift_register.sv
// Bidirectional serial/parallel shift register with a frame counter that
// pulses frame_done each time WIDTH shifts have accumulated.
module universal_shift_register #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic                        clk,
   input logic                        rst,
   universal_shift_register_if.slave  bus
);
   localparam int            CW   = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   mode_e            mode;
   logic [WIDTH-1:0] po_d, po_q;
   logic [CW-1:0]    bit_count_d, bit_count_q;
   logic             frame_done_d, frame_done_q;

   assign mode = mode_e'(bus.mode);

   always_comb begin
      po_d         = po_q;
      bit_count_d  = bit_count_q;
      frame_done_d = 1'b0;
      case (mode)
         MODE_SHR:  po_d = {bus.si, po_q[WIDTH-1:1]};
         MODE_SHL:  po_d = {po_q[WIDTH-2:0], bus.si};
         MODE_LOAD: begin
            po_d        = bus.pi;
            bit_count_d = '0;
         end
         default:   po_d = po_q;
      endcase
      // Both directions advance the same frame; a direction change keeps the count.
      if (mode == MODE_SHR || mode == MODE_SHL) begin
         if (bit_count_q == LAST) begin
            bit_count_d  = '0;
            frame_done_d = 1'b1;
         end else begin
            bit_count_d  = bit_count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         po_q         <= RESET_VALUE;
         bit_count_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         po_q         <= po_d;
         bit_count_q  <= bit_count_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.po         = po_q;
   assign bus.so         = (mode == MODE_SHL) ? po_q[WIDTH-1] : po_q[0];
   assign bus.bit_count  = bit_count_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: WIDTH=4 main instance plus
// WIDTH=2 and WIDTH=8 (RESET_VALUE=A5) instances for the parameter sweep.
module tb_universal_shift_register;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   universal_shift_register_if #(.WIDTH(4)) bus4 ();
   universal_shift_register_if #(.WIDTH(2)) bus2 ();
   universal_shift_register_if #(.WIDTH(8)) bus8 ();

   universal_shift_register #(.WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4));
   universal_shift_register #(.WIDTH(2), .RESET_VALUE(2'b01)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2));
   universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load4(input logic [3:0] val);
      bus4.mode = 2'b11;
      bus4.pi   = val;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus4.mode = 2'b00; bus4.si = 1'b0; bus4.pi = '0;
      bus2.mode = 2'b00; bus2.si = 1'b0; bus2.pi = '0;
      bus8.mode = 2'b00; bus8.si = 1'b0; bus8.pi = '0;
      tick(); tick();
      checks++; if (bus4.po !== 4'h0) begin errors++; $display("FAIL reset_po4: got %b expected 0000", bus4.po); end
      checks++; if (bus4.bit_count !== 2'd0) begin errors++; $display("FAIL reset_bc4: got %0d expected 0", bus4.bit_count); end
      checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd4: got %b expected 0", bus4.frame_done); end
      checks++; if (bus2.po !== 2'b01) begin errors++; $display("FAIL reset_po2: got %b expected 01", bus2.po); end
      checks++; if (bus8.po !== 8'hA5) begin errors++; $display("FAIL reset_po8: got %h expected a5", bus8.po); end
      rst = 1'b0;
   endtask

   task automatic test_mid_reset();
      load4(4'b1100);
      checks++; if (bus4.po !== 4'b1100) begin errors++; $display("FAIL midrst_load: got %b expected 1100", bus4.po); end
      bus4.mode = 2'b01; bus4.si = 1'b0; tick();
      bus4.si = 1'b1; tick();
      checks++; if (bus4.po !== 4'b1011) begin errors++; $display("FAIL midrst_pre_po: got %b expected 1011", bus4.po); end
      checks++; if (bus4.bit_count !== 2'd2) begin errors++; $display("FAIL midrst_pre_bc: got %0d expected 2", bus4.bit_count); end
      bus4.mode = 2'b00;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus4.po !== 4'h0) begin errors++; $display("FAIL midrst_po: got %b expected 0000", bus4.po); end
      checks++; if (bus4.bit_count !== 2'd0) begin errors++; $display("FAIL midrst_bc: got %0d expected 0", bus4.bit_count); end
      checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd: got %b expected 0", bus4.frame_done); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_sipo();
      logic [3:0] exp_po [4];
      logic [3:0] si_seq;
      exp_po[0] = 4'b1000; exp_po[1] = 4'b0100; exp_po[2] = 4'b1010; exp_po[3] = 4'b1101;
      si_seq = 4'b1101;
      bus4.mode = 2'b01;
      for (int k = 0; k < 4; k++) begin
         bus4.si = si_seq[k];
         tick();
         checks++; if (bus4.po !== exp_po[k]) begin errors++; $display("FAIL sipo_po[%0d]: got %b expected %b", k, bus4.po, exp_po[k]); end
         checks++; if (bus4.bit_count !== 2'((k + 1) % 4)) begin errors++; $display("FAIL sipo_bc[%0d]: got %0d expected %0d", k, bus4.bit_count, (k + 1) % 4); end
         checks++; if (bus4.frame_done !== (k == 3)) begin errors++; $display("FAIL sipo_fd[%0d]: got %b expected %b", k, bus4.frame_done, (k == 3)); end
      end
      bus4.mode = 2'b00; tick();
      checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL sipo_fd_pulse: got %b expected 0", bus4.frame_done); end
      checks++; if (bus4.po !== 4'b1101) begin errors++; $display("FAIL sipo_hold_po: got %b expected 1101", bus4.po); end
   endtask

   task automatic test_shift_left();
      logic [3:0] exp_po [4];
      logic [3:0] si_seq;
      exp_po[0] = 4'b0001; exp_po[1] = 4'b0011; exp_po[2] = 4'b0110; exp_po[3] = 4'b1101;
      si_seq = 4'b1011;
      load4(4'b0000);
      bus4.mode = 2'b10;
      for (int k = 0; k < 4; k++) begin
         bus4.si = si_seq[k];
         tick();
         checks++; if (bus4.po !== exp_po[k]) begin errors++; $display("FAIL shl_po[%0d]: got %b expected %b", k, bus4.po, exp_po[k]); end
         checks++; if (bus4.so !== exp_po[k][3]) begin errors++; $display("FAIL shl_so[%0d]: got %b expected %b", k, bus4.so, exp_po[k][3]); end
         checks++; if (bus4.frame_done !== (k == 3)) begin errors++; $display("FAIL shl_fd[%0d]: got %b expected %b", k, bus4.frame_done, (k == 3)); end
      end
      bus4.mode = 2'b00;
   endtask

   task automatic test_so_select();
      load4(4'b1000);
      for (int m = 0; m < 4; m++) begin
         bus4.mode = 2'(m);
         #1;
         checks++; if (bus4.so !== (m == 2)) begin errors++; $display("FAIL so_mode%0d: got %b expected %b", m, bus4.so, (m == 2)); end
      end
      bus4.mode = 2'b00;
   endtask

   task automatic test_load_serialise();
      logic [3:0] exp_so;
      exp_so = 4'b1001;
      load4(4'b1001);
      bus4.mode = 2'b01; bus4.si = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus4.so !== exp_so[k]) begin errors++; $display("FAIL ser_so[%0d]: got %b expected %b", k, bus4.so, exp_so[k]); end
         tick();
         checks++; if (bus4.frame_done !== (k == 3)) begin errors++; $display("FAIL ser_fd[%0d]: got %b expected %b", k, bus4.frame_done, (k == 3)); end
      end
      checks++; if (bus4.po !== 4'b0000) begin errors++; $display("FAIL ser_po_end: got %b expected 0000", bus4.po); end
      bus4.mode = 2'b00;
   endtask

   task automatic test_direction_change();
      logic [1:0] modes [4];
      logic [3:0] si_seq;
      logic [3:0] exp_po [4];
      modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b01; modes[3] = 2'b10;
      si_seq = 4'b1011;
      exp_po[0] = 4'b1000; exp_po[1] = 4'b0001; exp_po[2] = 4'b0000; exp_po[3] = 4'b0001;
      load4(4'b0000);
      for (int k = 0; k < 4; k++) begin
         bus4.mode = modes[k]; bus4.si = si_seq[k];
         tick();
         checks++; if (bus4.po !== exp_po[k]) begin errors++; $display("FAIL dir_po[%0d]: got %b expected %b", k, bus4.po, exp_po[k]); end
         checks++; if (bus4.frame_done !== (k == 3)) begin errors++; $display("FAIL dir_fd[%0d]: got %b expected %b", k, bus4.frame_done, (k == 3)); end
      end
      bus4.mode = 2'b00;
   endtask

   task automatic test_abort();
      load4(4'b0000);
      bus4.mode = 2'b01; bus4.si = 1'b1; tick(); tick();
      checks++; if (bus4.bit_count !== 2'd2) begin errors++; $display("FAIL abort_pre_bc: got %0d expected 2", bus4.bit_count); end
      load4(4'b0110);
      checks++; if (bus4.bit_count !== 2'd0) begin errors++; $display("FAIL abort_bc: got %0d expected 0", bus4.bit_count); end
      checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL abort_fd: got %b expected 0", bus4.frame_done); end
      checks++; if (bus4.po !== 4'b0110) begin errors++; $display("FAIL abort_po: got %b expected 0110", bus4.po); end
      // Two more shifts would close the old frame if the load had not restarted it.
      bus4.mode = 2'b01; bus4.si = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL abort_post_fd[%0d]: got %b expected 0", k, bus4.frame_done); end
         checks++; if (bus4.bit_count !== 2'(k + 1)) begin errors++; $display("FAIL abort_post_bc[%0d]: got %0d expected %0d", k, bus4.bit_count, k + 1); end
      end
      bus4.mode = 2'b00;
   endtask

   task automatic test_pause();
      load4(4'b0000);
      bus4.mode = 2'b01; bus4.si = 1'b1; tick(); tick();
      bus4.mode = 2'b00; bus4.si = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus4.po !== 4'b1100) begin errors++; $display("FAIL pause_po[%0d]: got %b expected 1100", k, bus4.po); end
         checks++; if (bus4.bit_count !== 2'd2) begin errors++; $display("FAIL pause_bc[%0d]: got %0d expected 2", k, bus4.bit_count); end
         checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL pause_fd[%0d]: got %b expected 0", k, bus4.frame_done); end
      end
      bus4.mode = 2'b01; bus4.si = 1'b0; tick();
      checks++; if (bus4.frame_done !== 1'b0) begin errors++; $display("FAIL pause_fd3: got %b expected 0", bus4.frame_done); end
      bus4.si = 1'b1; tick();
      checks++; if (bus4.po !== 4'b1011) begin errors++; $display("FAIL pause_po_end: got %b expected 1011", bus4.po); end
      checks++; if (bus4.frame_done !== 1'b1) begin errors++; $display("FAIL pause_fd4: got %b expected 1", bus4.frame_done); end
      checks++; if (bus4.bit_count !== 2'd0) begin errors++; $display("FAIL pause_bc_end: got %0d expected 0", bus4.bit_count); end
      bus4.mode = 2'b00;
   endtask

   task automatic test_param_sweep();
      logic [15:0] pat;
      pat = 16'h3CC3;
      bus2.mode = 2'b01; bus2.si = 1'b1;
      bus8.mode = 2'b10;
      for (int k = 1; k <= 16; k++) begin
         bus8.si = pat[16 - k];
         tick();
         checks++; if (bus2.bit_count !== 1'(k % 2)) begin errors++; $display("FAIL w2_bc[%0d]: got %0d expected %0d", k, bus2.bit_count, k % 2); end
         checks++; if (bus2.frame_done !== (k % 2 == 0)) begin errors++; $display("FAIL w2_fd[%0d]: got %b expected %b", k, bus2.frame_done, (k % 2 == 0)); end
         checks++; if (bus8.bit_count !== 3'(k % 8)) begin errors++; $display("FAIL w8_bc[%0d]: got %0d expected %0d", k, bus8.bit_count, k % 8); end
         checks++; if (bus8.frame_done !== (k % 8 == 0)) begin errors++; $display("FAIL w8_fd[%0d]: got %b expected %b", k, bus8.frame_done, (k % 8 == 0)); end
         if (k == 8) begin
            checks++; if (bus8.po !== 8'h3C) begin errors++; $display("FAIL w8_po8: got %h expected 3c", bus8.po); end
         end
      end
      checks++; if (bus8.po !== 8'hC3) begin errors++; $display("FAIL w8_po16: got %h expected c3", bus8.po); end
      checks++; if (bus2.po !== 2'b11) begin errors++; $display("FAIL w2_po: got %b expected 11", bus2.po); end
      bus2.mode = 2'b00; bus8.mode = 2'b00;
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_sipo();
      test_shift_left();
      test_so_select();
      test_load_serialise();
      test_direction_change();
      test_abort();
      test_pause();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
